// File: rtl/tdm_demux_1x4.sv
// ============================================================================
// Module  : tdm_demux_1x4
// Brief   : 4-slot TDM receive demux. It locks onto frame_sync and presents
//           each complete frame on y0..y3 with a one-cycle out_valid pulse.
//           Define TDM_DEMUX_PARITY_EN to add per-frame even-parity checking
//           through the din_par and par_err ports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux_1x4 #(
  parameter int WIDTH     = 8,
  parameter int SYNC_LOSS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic             din_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             out_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  localparam int           CW          = $clog2(SYNC_LOSS + 1);
  localparam logic [CW:0]  c_sync_loss = (CW+1)'(SYNC_LOSS);
  localparam logic [0:0]   c_hunt      = 1'b0;
  localparam logic [0:0]   c_locked    = 1'b1;

  logic [0:0]       r_state, w_state_nx;
  logic [1:0]       r_slot, w_slot_nx;
  logic [CW-1:0]    r_err_cnt, w_err_nx;
  logic [CW:0]      w_err_inc;
  logic             w_lose;
  logic             w_cap;
  logic [1:0]       w_cap_idx;
  logic             w_complete;
  logic             w_mis;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;

  assign w_err_inc = {1'b0, r_err_cnt} + (CW+1)'(1);
  assign w_lose    = (w_err_inc >= c_sync_loss);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_hunt;
      r_slot    <= 2'd0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_slot    <= w_slot_nx;
      r_err_cnt <= w_err_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_slot_nx  = r_slot;
    w_err_nx   = r_err_cnt;
    w_cap      = 1'b0;
    w_cap_idx  = 2'd0;
    w_complete = 1'b0;
    w_mis      = 1'b0;
    if (din_valid) begin
      case (r_state)
        c_hunt: begin
          if (frame_sync) begin
            w_state_nx = c_locked;
            w_slot_nx  = 2'd1;
            w_cap      = 1'b1;
          end
        end
        default: begin
          if (frame_sync && (r_slot != 2'd0)) begin
            w_mis = 1'b1;
            if (w_lose) begin
              w_state_nx = c_hunt;
              w_slot_nx  = 2'd0;
              w_err_nx   = '0;
            end else begin
              w_err_nx  = w_err_inc[CW-1:0];
              w_slot_nx = 2'd1;
              w_cap     = 1'b1;
            end
          end else if (r_slot == 2'd3) begin
            w_complete = 1'b1;
            w_slot_nx  = 2'd0;
            w_err_nx   = '0;
          end else begin
            w_cap     = 1'b1;
            w_cap_idx = r_slot;
            w_slot_nx = r_slot + 2'd1;
          end
        end
      endcase
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    locked = (r_state == c_locked);
    slot   = r_slot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh0     <= '0;
      r_sh1     <= '0;
      r_sh2     <= '0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= w_complete;
      sync_err  <= w_mis;
      if (w_cap) begin
        case (w_cap_idx)
          2'd0:    r_sh0 <= din;
          2'd1:    r_sh1 <= din;
          default: r_sh2 <= din;
        endcase
      end
      if (w_complete) begin
        y0 <= r_sh0;
        y1 <= r_sh1;
        y2 <= r_sh2;
        y3 <= din;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic w_bad;
  logic r_par_acc;

  assign w_bad = ^{din, din_par};

  // A slot-0 capture restarts the accumulator, so a discarded frame's flag never leaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_acc <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_err <= w_complete & (r_par_acc | w_bad);
      if (w_cap && (w_cap_idx == 2'd0))
        r_par_acc <= w_bad;
      else if (w_cap)
        r_par_acc <= r_par_acc | w_bad;
      else if (w_mis)
        r_par_acc <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x4.sv
// ============================================================================
// Module  : tb_tdm_demux_1x4
// Brief   : Directed self-checking bench for tdm_demux_1x4.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] y0, y1, y2, y3;
  logic       out_valid, locked, sync_err;
  logic [1:0] slot;
  logic       par_flip = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
  logic       din_par;
  logic       par_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  tdm_demux_1x4 #(.WIDTH(8), .SYNC_LOSS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .out_valid  (out_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = (^d) ^ par_flip;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({y0, y1, y2, y3, out_valid, locked, slot, sync_err} !== 37'd0) begin
      miscompares++;
      $display("FAIL reset_state: got y=%h ov=%b lk=%b slot=%0d se=%b, want all 0",
               {y0, y1, y2, y3}, out_valid, locked, slot, sync_err);
    end
    beat(8'h11, 1'b1); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h11223344 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL frame1_data: got y=%h ov=%b, want 11223344 ov=1", {y0, y1, y2, y3}, out_valid);
    end
    vectors++;
    if (locked !== 1'b1 || slot !== 2'd0) begin
      miscompares++;
      $display("FAIL frame1_lock: got lk=%b slot=%0d, want lk=1 slot=0", locked, slot);
    end
    idle(1);
    vectors++;
    if (out_valid !== 1'b0 || {y0, y1, y2, y3} !== 32'h11223344) begin
      miscompares++;
      $display("FAIL frame1_pulse: got ov=%b y=%h, want ov=0 y=11223344", out_valid, {y0, y1, y2, y3});
    end
  endtask

  task automatic test_hunt_drop;
    do_reset();
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
    vectors++;
    if (locked !== 1'b0 || slot !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_drop: got lk=%b slot=%0d ov=%b, want 0 0 0", locked, slot, out_valid);
    end
    beat(8'hAA, 1'b1); beat(8'hBB, 1'b0); beat(8'hCC, 1'b0); beat(8'hDD, 1'b0);
    vectors++;
    if ({y0, y1, y2, y3} !== 32'hAABBCCDD || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hunt_frame: got y=%h ov=%b, want aabbccdd ov=1", {y0, y1, y2, y3}, out_valid);
    end
  endtask

  task automatic test_misplaced_resync;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || out_valid !== 1'b0 || locked !== 1'b1 || slot !== 2'd1) begin
      miscompares++;
      $display("FAIL resync_err: got se=%b ov=%b lk=%b slot=%0d, want 1 0 1 1",
               sync_err, out_valid, locked, slot);
    end
    beat(8'h04, 1'b0);
    vectors++;
    if (sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL resync_pulse: got se=%b, want 0", sync_err);
    end
    beat(8'h05, 1'b0); beat(8'h06, 1'b0);
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h03040506 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL resync_frame: got y=%h ov=%b, want 03040506 ov=1", {y0, y1, y2, y3}, out_valid);
    end
  endtask

  task automatic test_sync_loss;
    beat(8'h01, 1'b0); beat(8'h02, 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1) begin
      miscompares++;
      $display("FAIL loss_first: got se=%b lk=%b slot=%0d, want 1 1 1", sync_err, locked, slot);
    end
    beat(8'h03, 1'b0); beat(8'h04, 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_second: got se=%b lk=%b slot=%0d ov=%b, want 1 0 0 0",
               sync_err, locked, slot, out_valid);
    end
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h03040506) begin
      miscompares++;
      $display("FAIL loss_hold: got y=%h, want 03040506", {y0, y1, y2, y3});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic [31:0] exp_y;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        d = 8'((f + 1) * 16 + k + 1);
        beat(d, k == 0);
        vectors++;
        if (out_valid !== (k == 3)) begin
          miscompares++;
          $display("FAIL b2b_valid f%0d k%0d: got ov=%b, want %b", f, k, out_valid, k == 3);
        end
      end
      exp_y = {8'((f + 1) * 16 + 1), 8'((f + 1) * 16 + 2), 8'((f + 1) * 16 + 3), 8'((f + 1) * 16 + 4)};
      vectors++;
      if ({y0, y1, y2, y3} !== exp_y) begin
        miscompares++;
        $display("FAIL b2b_data f%0d: got y=%h, want %h", f, {y0, y1, y2, y3}, exp_y);
      end
    end
    beat(8'hA0, 1'b1);
    idle(1);
    vectors++;
    if (out_valid !== 1'b0 || slot !== 2'd1) begin
      miscompares++;
      $display("FAIL gap_idle: got ov=%b slot=%0d, want 0 1", out_valid, slot);
    end
    beat(8'hA1, 1'b0);
    idle(2);
    beat(8'hA2, 1'b0);
    beat(8'hA3, 1'b0);
    vectors++;
    if ({y0, y1, y2, y3} !== 32'hA0A1A2A3 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_frame: got y=%h ov=%b, want a0a1a2a3 ov=1", {y0, y1, y2, y3}, out_valid);
    end
  endtask

  task automatic test_reset_midframe;
    beat(8'h77, 1'b1); beat(8'h88, 1'b0);
    vectors++;
    if (locked !== 1'b1 || slot !== 2'd2) begin
      miscompares++;
      $display("FAIL mid_pre: got lk=%b slot=%0d, want 1 2", locked, slot);
    end
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({y0, y1, y2, y3, out_valid, locked, slot, sync_err} !== 37'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got y=%h ov=%b lk=%b slot=%0d se=%b, want all 0",
               {y0, y1, y2, y3}, out_valid, locked, slot, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
    beat(8'h5A, 1'b1); beat(8'h6B, 1'b0); beat(8'h7C, 1'b0); beat(8'h8D, 1'b0);
    vectors++;
    if ({y0, y1, y2, y3} !== 32'h5A6B7C8D || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_post: got y=%h ov=%b, want 5a6b7c8d ov=1", {y0, y1, y2, y3}, out_valid);
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity;
    vectors++;
    if (par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_clean: got pe=%b, want 0", par_err);
    end
    beat(8'h13, 1'b1);
    par_flip = 1'b1;
    beat(8'h24, 1'b0);
    par_flip = 1'b0;
    beat(8'h35, 1'b0); beat(8'h46, 1'b0);
    vectors++;
    if (par_err !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL par_bad: got pe=%b ov=%b, want 1 1", par_err, out_valid);
    end
    idle(1);
    vectors++;
    if (par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_pulse: got pe=%b, want 0", par_err);
    end
    beat(8'h57, 1'b1); beat(8'h68, 1'b0); beat(8'h79, 1'b0); beat(8'h8A, 1'b0);
    vectors++;
    if (par_err !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL par_good: got pe=%b ov=%b, want 0 1", par_err, out_valid);
    end
  endtask
`endif

  initial begin
    rst        = 1'b1;
    din        = 8'h00;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = 1'b0;
`endif
    test_reset();
    test_hunt_drop();
    test_misplaced_resync();
    test_sync_loss();
    test_back_to_back();
    test_reset_midframe();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
